// File: rtl/crop_pixel_fifo.sv
// Output FIFO of the crop filter: buffers cropped pixels, tags frame
// position flags on write and presents a fall-through ready/valid stream.
module crop_pixel_fifo #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int OUT_ROWS        = 20,
  parameter int OUT_COLS        = 20,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [PIXEL_BIT_WIDTH-1:0]         in_pixel,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0]         m_pixel,
  output logic                               m_sof,
  output logic                               m_eol,
  output logic                               m_eof,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
  output logic                               overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int EW = PIXEL_BIT_WIDTH + 3;

  localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_LAST = CW'(OUT_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(OUT_ROWS - 1);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [LW-1:0] level_nxt;
  logic          wr_en;
  logic          rd_en;
  logic          sof;
  logic          eol;
  logic          eof;

  assign wr_en = in_valid && in_ready;
  assign rd_en = m_valid && m_ready;

  assign sof = (row == '0) && (col == '0);
  assign eol = (col == COL_LAST);
  assign eof = eol && (row == ROW_LAST);

  assign m_valid = (level != '0);
  assign {m_sof, m_eol, m_eof, m_pixel} = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (wr_en && !rd_en)
      level_nxt = level + LW'(1);
    else if (!wr_en && rd_en)
      level_nxt = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {sof, eol, eof, in_pixel};
  end

  // in_ready comes from the next level, never from m_ready directly
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_ready <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + AW'(1);
      level    <= level_nxt;
      in_ready <= (level_nxt != FULL);
      if (in_valid && !in_ready)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (wr_en) begin
      if (eol) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule
